// File: rtl/csr_file.sv
// Machine-mode CSR file and trap/MRET sequencer. It takes writeback CSR writes, traps and MRETs,
// feeds decode with CSR read data, privilege and interrupt status, and gives fetch a redirect target.
module csr_file #(
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter logic [63:0] HART_ID     = 64'h0,
    parameter logic [63:0] MISA_VAL    = 64'h8000000000000100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_V,
    input  logic        WB_ST_CSR,
    input  logic [11:0] WB_CSR_ADDR,
    input  logic [63:0] WB_CSR_DATA,
    input  logic        WB_CS,
    input  logic [63:0] WB_CAUSE,
    input  logic [63:0] WB_PC,
    input  logic [63:0] WB_TVAL,
    input  logic        WB_MRET,
    input  logic        TIMER,
    input  logic        EXTERNAL,
    input  logic [11:0] DE_CSR_ADDR,
    output logic [63:0] DE_CSR_RDATA,
    output logic        DE_CSR_ILLEGAL,
    output logic        PRIVILEGE,
    output logic        IRQ_PENDING,
    output logic        CSR_BUSY,
    output logic        TRAP_PC_MUX,
    output logic [63:0] TRAP_TARGET
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_RET      = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t      state_r;
    logic        priv_r;
    logic        mstatus_mie_r;
    logic        mpie_r;
    logic [1:0]  mpp_r;
    logic [63:0] mie_r;
    logic [63:0] mtvec_r;
    logic [63:0] mscratch_r;
    logic [63:0] mepc_r;
    logic [63:0] mcause_r;
    logic [63:0] mtval_r;
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;
    logic [63:0] pc_lat_r;
    logic [63:0] cause_lat_r;
    logic [63:0] tval_lat_r;
    logic        trap_pc_mux_r;
    logic [63:0] trap_target_r;

    logic        accept_s;
    logic        take_trap_s;
    logic        take_ret_s;
    logic        csr_wr_s;
    logic        retire_s;
    logic [63:0] mip_s;
    logic [63:0] mstatus_s;
    logic [63:0] trap_base_s;
    logic [63:0] vec_target_s;
    logic [63:0] rd_data_s;
    logic        implemented_s;

    assign accept_s     = (state_r == ST_IDLE) & WB_V;
    assign take_trap_s  = accept_s & WB_CS;
    assign take_ret_s   = accept_s & ~WB_CS & WB_MRET;
    assign csr_wr_s     = accept_s & ~WB_CS & ~WB_MRET & WB_ST_CSR;
    assign retire_s     = accept_s & ~WB_CS;
    assign mip_s        = {52'd0, EXTERNAL, 3'd0, TIMER, 7'd0};
    assign mstatus_s    = {51'd0, mpp_r, 3'd0, mpie_r, 3'd0, mstatus_mie_r, 3'd0};
    assign trap_base_s  = {mtvec_r[63:2], 2'b00};
    // Vectored mode only applies to interrupts: base + 4 * cause code.
    assign vec_target_s = trap_base_s + {56'd0, cause_lat_r[5:0], 2'b00};

    assign PRIVILEGE   = priv_r;
    assign CSR_BUSY    = (state_r != ST_IDLE);
    assign TRAP_PC_MUX = trap_pc_mux_r;
    assign TRAP_TARGET = trap_target_r;
    assign IRQ_PENDING = mstatus_mie_r & (|(mie_r & mip_s));

    // Sequencer plus architectural CSR state (all except the counters).
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r       <= ST_IDLE;
            priv_r        <= 1'b1;
            mstatus_mie_r <= 1'b0;
            mpie_r        <= 1'b0;
            mpp_r         <= 2'b00;
            mie_r         <= 64'd0;
            mtvec_r       <= MTVEC_RESET & ~64'h2;
            mscratch_r    <= 64'd0;
            mepc_r        <= 64'd0;
            mcause_r      <= 64'd0;
            mtval_r       <= 64'd0;
            pc_lat_r      <= 64'd0;
            cause_lat_r   <= 64'd0;
            tval_lat_r    <= 64'd0;
            trap_pc_mux_r <= 1'b0;
            trap_target_r <= 64'd0;
        end else begin
            trap_pc_mux_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_trap_s) begin
                        pc_lat_r    <= WB_PC;
                        cause_lat_r <= WB_CAUSE;
                        tval_lat_r  <= WB_TVAL;
                        state_r     <= ST_TRAP;
                    end else if (take_ret_s) begin
                        state_r <= ST_RET;
                    end else if (csr_wr_s) begin
                        case (WB_CSR_ADDR)
                            12'h300: begin
                                mstatus_mie_r <= WB_CSR_DATA[3];
                                mpie_r        <= WB_CSR_DATA[7];
                                mpp_r         <= (WB_CSR_DATA[12:11] == 2'b11) ? 2'b11 : 2'b00;
                            end
                            12'h304: mie_r      <= WB_CSR_DATA;
                            12'h305: mtvec_r    <= WB_CSR_DATA & ~64'h2;
                            12'h340: mscratch_r <= WB_CSR_DATA;
                            12'h341: mepc_r     <= WB_CSR_DATA & ~64'h3;
                            12'h342: mcause_r   <= WB_CSR_DATA;
                            12'h343: mtval_r    <= WB_CSR_DATA;
                            default: ;
                        endcase
                    end
                end
                ST_TRAP: begin
                    mepc_r        <= pc_lat_r & ~64'h3;
                    mcause_r      <= cause_lat_r;
                    mtval_r       <= tval_lat_r;
                    mpie_r        <= mstatus_mie_r;
                    mstatus_mie_r <= 1'b0;
                    mpp_r         <= priv_r ? 2'b11 : 2'b00;
                    priv_r        <= 1'b1;
                    trap_pc_mux_r <= 1'b1;
                    trap_target_r <= (mtvec_r[0] & cause_lat_r[63]) ? vec_target_s : trap_base_s;
                    state_r       <= ST_REDIRECT;
                end
                ST_RET: begin
                    priv_r        <= (mpp_r == 2'b11);
                    mstatus_mie_r <= mpie_r;
                    mpie_r        <= 1'b1;
                    mpp_r         <= 2'b00;
                    trap_pc_mux_r <= 1'b1;
                    trap_target_r <= mepc_r;
                    state_r       <= ST_REDIRECT;
                end
                ST_REDIRECT: state_r <= ST_IDLE;
                default:     state_r <= ST_IDLE;
            endcase
        end
    end

    // Performance counters; an explicit CSR write takes precedence over the increment.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mcycle_r   <= 64'd0;
            minstret_r <= 64'd0;
        end else begin
            if (csr_wr_s && (WB_CSR_ADDR == 12'hB00)) begin
                mcycle_r <= WB_CSR_DATA;
            end else begin
                mcycle_r <= mcycle_r + 64'd1;
            end
            if (csr_wr_s && (WB_CSR_ADDR == 12'hB02)) begin
                minstret_r <= WB_CSR_DATA;
            end else if (retire_s) begin
                minstret_r <= minstret_r + 64'd1;
            end else begin
                minstret_r <= minstret_r;
            end
        end
    end

    // Decode-side read port, straight from the current register values.
    always_comb begin
        rd_data_s     = 64'd0;
        implemented_s = 1'b1;
        case (DE_CSR_ADDR)
            12'h300: rd_data_s = mstatus_s;
            12'h301: rd_data_s = MISA_VAL;
            12'h304: rd_data_s = mie_r;
            12'h305: rd_data_s = mtvec_r;
            12'h340: rd_data_s = mscratch_r;
            12'h341: rd_data_s = mepc_r;
            12'h342: rd_data_s = mcause_r;
            12'h343: rd_data_s = mtval_r;
            12'h344: rd_data_s = mip_s;
            12'hB00: rd_data_s = mcycle_r;
            12'hB02: rd_data_s = minstret_r;
            12'hF14: rd_data_s = HART_ID;
            default: begin
                rd_data_s     = 64'd0;
                implemented_s = 1'b0;
            end
        endcase
        DE_CSR_RDATA   = rd_data_s;
        DE_CSR_ILLEGAL = ~implemented_s |
                         (~priv_r & (DE_CSR_ADDR != 12'hB00) & (DE_CSR_ADDR != 12'hB02));
    end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus a random phase, checked against a
// transaction-level model of the machine-mode CSR rules.
module tb_csr_file;

    localparam logic [63:0] MTVEC_RS = 64'h0000_0000_0000_0100;
    localparam logic [63:0] HART     = 64'd3;
    localparam logic [63:0] MISA     = 64'h8000000000000100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WB_V, WB_ST_CSR, WB_CS, WB_MRET, TIMER, EXTERNAL;
    logic [11:0] WB_CSR_ADDR, DE_CSR_ADDR;
    logic [63:0] WB_CSR_DATA, WB_CAUSE, WB_PC, WB_TVAL;
    logic [63:0] DE_CSR_RDATA, TRAP_TARGET;
    logic        DE_CSR_ILLEGAL, PRIVILEGE, IRQ_PENDING, CSR_BUSY, TRAP_PC_MUX;

    csr_file #(.MTVEC_RESET(MTVEC_RS), .HART_ID(HART), .MISA_VAL(MISA)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_ST_CSR(WB_ST_CSR),
        .WB_CSR_ADDR(WB_CSR_ADDR), .WB_CSR_DATA(WB_CSR_DATA), .WB_CS(WB_CS),
        .WB_CAUSE(WB_CAUSE), .WB_PC(WB_PC), .WB_TVAL(WB_TVAL), .WB_MRET(WB_MRET),
        .TIMER(TIMER), .EXTERNAL(EXTERNAL), .DE_CSR_ADDR(DE_CSR_ADDR),
        .DE_CSR_RDATA(DE_CSR_RDATA), .DE_CSR_ILLEGAL(DE_CSR_ILLEGAL),
        .PRIVILEGE(PRIVILEGE), .IRQ_PENDING(IRQ_PENDING), .CSR_BUSY(CSR_BUSY),
        .TRAP_PC_MUX(TRAP_PC_MUX), .TRAP_TARGET(TRAP_TARGET)
    );

    always #50 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_priv, m_smie, m_mpie;
    logic [1:0]  m_mpp;
    logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;

    logic [11:0] addr_list [0:15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14,
                                      12'h000, 12'h7C0, 12'hB01, 12'h345};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_priv = 1'b1; m_smie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b00;
        m_mie = 64'd0; m_mtvec = MTVEC_RS & ~64'h2; m_mscratch = 64'd0; m_mepc = 64'd0;
        m_mcause = 64'd0; m_mtval = 64'd0; m_mcycle = 64'd0; m_minstret = 64'd0;
    endtask

    function automatic logic [63:0] exp_read(input logic [11:0] a);
        case (a)
            12'h300: return (64'(m_smie) << 3) | (64'(m_mpie) << 7) | (64'(m_mpp) << 11);
            12'h301: return MISA;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return (64'(EXTERNAL) << 11) | (64'(TIMER) << 7);
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            12'hF14: return HART;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic exp_illegal(input logic [11:0] a);
        logic impl;
        impl = 1'b0;
        foreach (addr_list[i]) if (i < 12 && addr_list[i] == a) impl = 1'b1;
        return !impl || (!m_priv && a != 12'hB00 && a != 12'hB02);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (RESET) m_mcycle++;
        else model_reset();
    endtask

    task automatic drive_idle();
        WB_V = 1'b0; WB_ST_CSR = 1'b0; WB_CS = 1'b0; WB_MRET = 1'b0;
        WB_CSR_ADDR = 12'd0; WB_CSR_DATA = 64'd0; WB_CAUSE = 64'd0; WB_PC = 64'd0; WB_TVAL = 64'd0;
    endtask

    // Busy-time garbage on the WB bus that must have no effect.
    task automatic junk_busy();
        WB_V = 1'b1; WB_ST_CSR = 1'b1; WB_CSR_ADDR = 12'h340; WB_CSR_DATA = {$urandom, $urandom};
        WB_CS = 1'($urandom_range(0, 1)); WB_MRET = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all();
        for (int i = 0; i < 16; i++) begin
            DE_CSR_ADDR = addr_list[i];
            #1;
            check($sformatf("rd_%h", addr_list[i]), DE_CSR_RDATA, exp_read(addr_list[i]));
            check1($sformatf("ill_%h", addr_list[i]), DE_CSR_ILLEGAL, exp_illegal(addr_list[i]));
        end
        check1("irq", IRQ_PENDING, m_smie & (|(m_mie & exp_read(12'h344))));
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
        DE_CSR_ADDR = a;
        #1;
        check(tag, DE_CSR_RDATA, exp);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        WB_V = 1'b1; WB_ST_CSR = 1'b1; WB_CSR_ADDR = a; WB_CSR_DATA = d;
        tick();
        drive_idle();
        m_minstret++;
        case (a)
            12'h300: begin
                m_smie = d[3]; m_mpie = d[7];
                m_mpp = (d[12:11] == 2'b11) ? 2'b11 : 2'b00;
            end
            12'h304: m_mie = d;
            12'h305: m_mtvec = d & ~64'h2;
            12'h340: m_mscratch = d;
            12'h341: m_mepc = d & ~64'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            12'hB00: m_mcycle = d;
            12'hB02: m_minstret = d;
            default: ;
        endcase
    endtask

    task automatic plain_cycle(input logic v);
        WB_V = v; WB_ST_CSR = ~v; WB_CSR_ADDR = 12'h340; WB_CSR_DATA = {$urandom, $urandom};
        tick();
        drive_idle();
        if (v) m_minstret++;
    endtask

    task automatic do_trap(input logic [63:0] cause, input logic [63:0] pc,
                           input logic [63:0] tval, input logic with_st);
        logic [63:0] exp_t;
        WB_V = 1'b1; WB_CS = 1'b1; WB_CAUSE = cause; WB_PC = pc; WB_TVAL = tval;
        WB_ST_CSR = with_st; WB_MRET = with_st; WB_CSR_ADDR = 12'h340; WB_CSR_DATA = 64'hBAD0BAD0;
        tick();
        if (m_mtvec[0] && cause[63]) exp_t = (m_mtvec & ~64'h3) + ((cause & 64'd63) << 2);
        else exp_t = m_mtvec & ~64'h3;
        junk_busy();
        check1("trap_busy1", CSR_BUSY, 1'b1);
        check1("trap_mux1", TRAP_PC_MUX, 1'b0);
        tick();
        m_mepc = pc & ~64'h3; m_mcause = cause; m_mtval = tval;
        m_mpie = m_smie; m_smie = 1'b0; m_mpp = m_priv ? 2'b11 : 2'b00; m_priv = 1'b1;
        check1("trap_busy2", CSR_BUSY, 1'b1);
        check1("trap_mux2", TRAP_PC_MUX, 1'b1);
        check("trap_target", TRAP_TARGET, exp_t);
        check1("trap_priv", PRIVILEGE, m_priv);
        tick();
        drive_idle();
        check1("trap_busy3", CSR_BUSY, 1'b0);
        check1("trap_mux3", TRAP_PC_MUX, 1'b0);
    endtask

    task automatic do_mret();
        logic [63:0] exp_t;
        WB_V = 1'b1; WB_MRET = 1'b1;
        tick();
        m_minstret++;
        exp_t = m_mepc;
        junk_busy();
        check1("ret_busy1", CSR_BUSY, 1'b1);
        check1("ret_mux1", TRAP_PC_MUX, 1'b0);
        tick();
        m_priv = (m_mpp == 2'b11); m_smie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
        check1("ret_mux2", TRAP_PC_MUX, 1'b1);
        check("ret_target", TRAP_TARGET, exp_t);
        check1("ret_priv", PRIVILEGE, m_priv);
        tick();
        drive_idle();
        check1("ret_busy3", CSR_BUSY, 1'b0);
        check1("ret_mux3", TRAP_PC_MUX, 1'b0);
    endtask

    initial begin
        logic [63:0] snap;
        int op;
        RESET = 1'b0; TIMER = 1'b0; EXTERNAL = 1'b0; DE_CSR_ADDR = 12'd0;
        drive_idle();
        model_reset();
        tick();
        tick();
        check1("rst_busy", CSR_BUSY, 1'b0);
        check1("rst_mux", TRAP_PC_MUX, 1'b0);
        check1("rst_priv", PRIVILEGE, 1'b1);
        check("rst_target", TRAP_TARGET, 64'd0);
        read_chk("rst_mtvec", 12'h305, MTVEC_RS);
        read_chk("rst_mstatus", 12'h300, 64'd0);
        check_all();
        RESET = 1'b1;
        tick();
        read_chk("mcycle_1", 12'hB00, 64'd1);

        csr_write(12'h340, 64'hDEADBEEF);
        read_chk("mscratch", 12'h340, 64'hDEADBEEF);
        csr_write(12'h341, 64'h1003);
        read_chk("mepc_mask", 12'h341, 64'h1000);
        check_all();

        // Vectored interrupt, then synchronous exception with the same mtvec
        csr_write(12'h305, 64'h8000_0001);
        csr_write(12'h300, 64'h8);
        do_trap(64'h8000000000000007, 64'h2000, 64'd0, 1'b0);
        read_chk("vec_mepc", 12'h341, 64'h2000);
        read_chk("vec_mstatus", 12'h300, 64'h1880);
        do_trap(64'd2, 64'h2100, 64'h55, 1'b0);
        check_all();

        // Trap with a simultaneous CSR write and MRET: write dropped, no retire
        csr_write(12'h340, 64'h1111);
        snap = m_minstret;
        do_trap(64'd2, 64'h2200, 64'd0, 1'b1);
        read_chk("drop_mscratch", 12'h340, 64'h1111);
        read_chk("drop_minstret", 12'hB02, snap);

        // Counter wrap and write-over-increment
        csr_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        read_chk("mcycle_wr", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        plain_cycle(1'b0);
        read_chk("mcycle_wrap", 12'hB00, 64'd0);
        csr_write(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        plain_cycle(1'b1);
        read_chk("minstret_wrap", 12'hB02, 64'd0);

        // User mode round trip
        csr_write(12'h300, 64'h0);
        csr_write(12'h341, 64'h3000);
        do_mret();
        check1("user_priv", PRIVILEGE, 1'b0);
        DE_CSR_ADDR = 12'h300; #1;
        check1("user_ill_mstatus", DE_CSR_ILLEGAL, 1'b1);
        DE_CSR_ADDR = 12'hB00; #1;
        check1("user_ok_mcycle", DE_CSR_ILLEGAL, 1'b0);
        do_trap(64'd8, 64'h3004, 64'd0, 1'b0);
        read_chk("ecall_mstatus", 12'h300, 64'h0);
        do_mret();
        check("ret_to_3004", TRAP_TARGET, 64'h3004);
        check_all();

        // Reset in the TRAP cycle: no redirect, back to machine mode
        WB_V = 1'b1; WB_CS = 1'b1; WB_CAUSE = 64'd8; WB_PC = 64'h3008;
        tick();
        drive_idle();
        RESET = 1'b0;
        tick();
        check1("rstmid_mux", TRAP_PC_MUX, 1'b0);
        check1("rstmid_busy", CSR_BUSY, 1'b0);
        check1("rstmid_priv", PRIVILEGE, 1'b1);
        RESET = 1'b1;
        tick();
        check1("rstmid_mux2", TRAP_PC_MUX, 1'b0);
        check_all();

        // Random phase
        for (int it = 0; it < 60; it++) begin
            TIMER = 1'($urandom_range(0, 1));
            EXTERNAL = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            if (op <= 4) csr_write(addr_list[$urandom_range(0, 15)], {$urandom, $urandom});
            else if (op <= 6) do_trap({$urandom, $urandom}, {$urandom, $urandom},
                                      {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            else if (op == 7 && m_priv) do_mret();
            else if (op == 9) plain_cycle(1'b0);
            else plain_cycle(1'b1);
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode control/status register file and trap sequencer, sitting at the receiving end of the writeback stage.
- Consumes the writeback CSR write strobe/data, trap request (WB_CS) and cause (WB_CAUSE).
- Performs the trap-entry and MRET context-switch sequences.
- Supplies decode with CSR read data, the current privilege level and a pending-interrupt flag.
- Supplies fetch with a redirect target.

Parameters:
MTVEC_RESET, 64'h0, reset value of mtvec
HART_ID, 0, value returned by mhartid
MISA_VAL, 64'h8000000000000100, read-only misa value (RV64I)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-low reset
WB_V  in  1  writeback instruction valid
WB_ST_CSR  in  1  CSR write strobe from writeback
WB_CSR_ADDR  in  12  CSR address (WB instruction bits 31:20)
WB_CSR_DATA  in  64  CSR write data
WB_CS  in  1  trap request from writeback trap handler
WB_CAUSE  in  64  trap cause; bit63=interrupt
WB_PC  in  64  PC of the instruction in writeback
WB_TVAL  in  64  faulting address/instruction for mtval
WB_MRET  in  1  MRET in writeback
TIMER  in  1  timer interrupt line (mip.MTIP)
EXTERNAL  in  1  external interrupt line (mip.MEIP)
DE_CSR_ADDR  in  12  decode read address
DE_CSR_RDATA  out  64  combinational read data
DE_CSR_ILLEGAL  out  1  unimplemented address, or user-mode access
PRIVILEGE  out  1  1=machine, 0=user
IRQ_PENDING  out  1  mstatus.MIE & |(mie & mip)
CSR_BUSY  out  1  sequencer not IDLE; pipeline stalls
TRAP_PC_MUX  out  1  one-cycle redirect pulse
TRAP_TARGET  out  64  redirect address, valid with TRAP_PC_MUX

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP bits12:11 (legal values 00/11 only).
  - misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344 (RO; bit7=TIMER, bit11=EXTERNAL).
  - mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO).
- Write masking:
  - Writes to RO/unimplemented addresses are ignored.
  - mepc[1:0] reads 0.
  - mtvec[1] reads 0.
  - mstatus: only bits 3, 7 and 12:11 are writable. A write of MPP=01/10 stores 00.
- Reset (RESET=0 at a CLK edge):
  - PRIVILEGE=1, state=IDLE.
  - All CSRs 0, except mtvec=MTVEC_RESET.
  - TRAP_PC_MUX=0, CSR_BUSY=0, TRAP_TARGET=0.
  - Reset mid-sequence aborts the sequence; no redirect is issued.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when WB_V & ~WB_CS & ~CSR_BUSY.
  - A CSR write to a counter in the same cycle wins over its increment.
  - Both counters wrap at 2^64.
- State machine: IDLE, TRAP, RET, REDIRECT.
  - Inputs are acted on only in IDLE with WB_V=1. In other states CSR_BUSY=1 and all WB inputs are ignored.
  - IDLE & WB_CS → TRAP. Priority: WB_CS > WB_MRET > WB_ST_CSR. A CSR write or MRET accompanied by WB_CS is dropped.
  - TRAP cycle:
    - mepc<=WB_PC captured (latched in IDLE); mcause<=WB_CAUSE; mtval<=WB_TVAL.
    - MPIE<=MIE; MIE<=0; MPP<=PRIVILEGE?11:00; PRIVILEGE<=1.
    - Then → REDIRECT.
  - IDLE & WB_MRET (no WB_CS) → RET. MRET in user mode is not handled here; decode raises an illegal-instruction trap instead.
  - RET cycle: PRIVILEGE<=(MPP==11); MIE<=MPIE; MPIE<=1; MPP<=00; then → REDIRECT.
  - REDIRECT: TRAP_PC_MUX=1 for exactly one cycle, then → IDLE. TRAP_TARGET is:
    - after RET: mepc.
    - after TRAP, when mtvec[0]=1 and mcause[63]=1: {mtvec[63:2],2'b00} + 4*mcause[5:0].
    - otherwise after TRAP: {mtvec[63:2],2'b00}.
- CSR write: in IDLE, WB_V & WB_ST_CSR & ~WB_CS & ~WB_MRET writes at the next edge. Latency is 1 cycle; a decode read in the following cycle sees the new value (no internal bypass).
- DE_CSR_RDATA/DE_CSR_ILLEGAL are combinational from the current registers. ILLEGAL=1 when the address is unimplemented, or when PRIVILEGE=0 and the address is not 0xB00/0xB02.
- IRQ_PENDING is combinational. It is gated by MIE regardless of privilege.

Test Plan:
- Reset → PRIVILEGE=1, mtvec=MTVEC_RESET, mstatus=0, CSR_BUSY=0, TRAP_PC_MUX=0; mcycle=1 one cycle after reset release.
- Write mscratch=64'hDEADBEEF via WB_ST_CSR → next-cycle read of 0x340 returns DEADBEEF. Write mepc=64'h1003 → reads 64'h1000.
- mtvec=64'h8000_0001, MIE=1; WB_CS with cause=64'h8000000000000007, WB_PC=64'h2000 → 2 busy cycles, then TRAP_PC_MUX pulse with TARGET=64'h8000001C. Afterwards mepc=2000, MIE=0, MPIE=1, MPP=11.
- Synchronous exception: cause=2, mtvec=64'h8000_0001 → TARGET=64'h80000000 (non-vectored).
- WB_CS and WB_ST_CSR to mscratch in the same cycle → mscratch unchanged, trap taken, minstret not incremented.
- From user mode (via MRET with MPP=00): DE_CSR_ADDR=0x300 → ILLEGAL=1. Then ecall trap → PRIVILEGE=1, MPP=00. MRET → TARGET=mepc, PRIVILEGE=0. Assert reset during TRAP → no pulse, PRIVILEGE=1.
